// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes and their face values.
package vm_pkg;

    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_5  = 2'b01,
        COIN_10 = 2'b10
    } coin_code_t;

    localparam int VAL_W = 4;

    localparam logic [VAL_W-1:0] VAL_1  = 4'd1;
    localparam logic [VAL_W-1:0] VAL_5  = 4'd5;
    localparam logic [VAL_W-1:0] VAL_10 = 4'd10;

    // Face value of a coin code; the reserved code 11 is worth nothing.
    function automatic logic [VAL_W-1:0] coin_value(input coin_code_t code);
        case (code)
            COIN_1:  coin_value = VAL_1;
            COIN_5:  coin_value = VAL_5;
            COIN_10: coin_value = VAL_10;
            default: coin_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: largest coin whose value does not exceed the amount owed.
module change_coin_select
    import vm_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    output coin_code_t       code,
    output logic [VAL_W-1:0] value
);

    // Pick 10, then 5, then 1; an amount of zero yields a zero-valued coin so nothing is subtracted.
    always_comb begin
        code  = COIN_1;
        value = '0;
        if (remaining >= AMT_W'(VAL_10)) begin
            code  = COIN_10;
            value = VAL_10;
        end else if (remaining >= AMT_W'(VAL_5)) begin
            code  = COIN_5;
            value = VAL_5;
        end else if (remaining != '0) begin
            code  = COIN_1;
            value = VAL_1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: hands coins to the hopper one at a time until the owed amount is paid.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_req,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             coin_ack,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    output logic [AMT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE,
        FAULT
    } state_t;

    localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    state_t             state, state_d;
    logic [AMT_W-1:0]   remaining_d;
    logic [WAIT_W-1:0]  wait_cnt, wait_d;
    logic [VAL_W-1:0]   cur_val, cur_val_d;
    logic [1:0]         coin_out_d;
    logic               coin_valid_d, busy_d, done_d, err_d;
    coin_code_t         sel_code;
    logic [VAL_W-1:0]   sel_val;

    // The coin shown next cycle is chosen from the amount that will be owed next cycle.
    change_coin_select #(
        .AMT_W(AMT_W)
    ) u_select (
        .remaining(remaining_d),
        .code     (sel_code),
        .value    (sel_val)
    );

    // Register every output together with the controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            wait_cnt   <= '0;
            cur_val    <= '0;
            coin_out   <= 2'b00;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            remaining  <= remaining_d;
            wait_cnt   <= wait_d;
            cur_val    <= cur_val_d;
            coin_out   <= coin_out_d;
            coin_valid <= coin_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Next-state logic: accept requests in IDLE, step through coins on ack, give up after the ack timeout.
    always_comb begin
        state_d      = state;
        remaining_d  = remaining;
        wait_d       = wait_cnt;
        coin_valid_d = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;
        err_d        = err;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                err_d  = 1'b0;
                if (change_req) begin
                    remaining_d = change_amt;
                    busy_d      = 1'b1;
                    wait_d      = '0;
                    if (change_amt != '0) begin
                        state_d      = ISSUE;
                        coin_valid_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (coin_ack) begin
                    remaining_d = remaining - AMT_W'(cur_val);
                    wait_d      = '0;
                    if (remaining_d == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        coin_valid_d = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end else begin
                    wait_d       = wait_cnt + WAIT_W'(1);
                    coin_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            FAULT: begin
                busy_d = 1'b1;
                err_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Latch a fresh coin only when one will be presented; otherwise keep the last code shown.
    always_comb begin
        coin_out_d = coin_out;
        cur_val_d  = cur_val;
        if (coin_valid_d) begin
            coin_out_d = sel_code;
            cur_val_d  = sel_val;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for the change dispenser.
module tb_change_dispenser;

    localparam int AMT_W       = 8;
    localparam int ACK_TIMEOUT = 255;

    logic             clk;
    logic             rst;
    logic             change_req;
    logic [AMT_W-1:0] change_amt;
    logic             coin_ack;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic [AMT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic             err;

    int check_count = 0;
    int fail_count  = 0;
    int paid_total  = 0;
    int coin_count  = 0;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .change_req(change_req),
        .change_amt(change_amt),
        .coin_ack  (coin_ack),
        .coin_out  (coin_out),
        .coin_valid(coin_valid),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tally the value of every coin handed over at a clock edge.
    always @(posedge clk) begin
        if (!rst && coin_valid && coin_ack) begin
            coin_count <= coin_count + 1;
            case (coin_out)
                2'b00:   paid_total <= paid_total + 1;
                2'b01:   paid_total <= paid_total + 5;
                2'b10:   paid_total <= paid_total + 10;
                default: paid_total <= paid_total + 1000;
            endcase
        end
    end

    task automatic applyStimulus(input logic r, input logic req, input int amt, input logic ack);
        rst        = r;
        change_req = req;
        change_amt = AMT_W'(amt);
        coin_ack   = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkCoin(input string tag, input logic [1:0] code, input int rem);
        checkOutput({tag, " coin_valid"}, 32'(coin_valid), 32'd1);
        checkOutput({tag, " coin_out"}, 32'(coin_out), 32'(code));
        checkOutput({tag, " remaining"}, 32'(remaining), 32'(rem));
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, " coin_valid"}, 32'(coin_valid), 32'd0);
        checkOutput({tag, " coin_out"}, 32'(coin_out), 32'd0);
        checkOutput({tag, " remaining"}, 32'(remaining), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int paid_before;
        int coins_before;
        logic valid_held;

        rst        = 1'b1;
        change_req = 1'b0;
        change_amt = '0;
        coin_ack   = 1'b0;

        // Reset values
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkIdleReset("reset");

        // ack while idle is ignored
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkIdleReset("idle_ack");

        // 27 paid with an ack every cycle: 10,10,5,1,1
        paid_before = paid_total;
        applyStimulus(1'b0, 1'b1, 27, 1'b0);
        checkCoin("amt27_c1", 2'b10, 27);
        checkOutput("amt27_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt27_c2", 2'b10, 17);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt27_c3", 2'b01, 7);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt27_c4", 2'b00, 2);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt27_c5", 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("amt27_done", 32'(done), 32'd1);
        checkOutput("amt27_valid_off", 32'(coin_valid), 32'd0);
        checkOutput("amt27_rem0", 32'(remaining), 32'd0);
        checkOutput("amt27_paid", 32'(paid_total - paid_before), 32'd27);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("amt27_done_pulse", 32'(done), 32'd0);
        checkOutput("amt27_busy_low", 32'(busy), 32'd0);

        // Zero amount completes immediately
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("amt0_done", 32'(done), 32'd1);
        checkOutput("amt0_valid", 32'(coin_valid), 32'd0);
        checkOutput("amt0_rem", 32'(remaining), 32'd0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("amt0_done_pulse", 32'(done), 32'd0);
        checkOutput("amt0_busy", 32'(busy), 32'd0);

        // 6 with ack withheld for four cycles
        applyStimulus(1'b0, 1'b1, 6, 1'b0);
        checkCoin("amt6_hold0", 2'b01, 6);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            checkCoin($sformatf("amt6_hold%0d", i), 2'b01, 6);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt6_second", 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("amt6_done", 32'(done), 32'd1);
        checkOutput("amt6_rem0", 32'(remaining), 32'd0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("amt6_busy_low", 32'(busy), 32'd0);

        // 20 with a second request during payout
        paid_before  = paid_total;
        coins_before = coin_count;
        applyStimulus(1'b0, 1'b1, 20, 1'b0);
        checkCoin("amt20_c1", 2'b10, 20);
        applyStimulus(1'b0, 1'b1, 3, 1'b1);
        checkCoin("amt20_c2", 2'b10, 10);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("amt20_done", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("amt20_coins", 32'(coin_count - coins_before), 32'd2);
        checkOutput("amt20_paid", 32'(paid_total - paid_before), 32'd20);
        checkOutput("amt20_idle_valid", 32'(coin_valid), 32'd0);
        checkOutput("amt20_busy_low", 32'(busy), 32'd0);

        // Reset after the first ack of 15
        applyStimulus(1'b0, 1'b1, 15, 1'b0);
        checkCoin("amt15_c1", 2'b10, 15);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkCoin("amt15_c2", 2'b01, 5);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkIdleReset("amt15_reset");
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkIdleReset("amt15_after");

        // 10 with no ack: fault after ACK_TIMEOUT cycles of waiting
        applyStimulus(1'b0, 1'b1, 10, 1'b0);
        checkCoin("tmo_start", 2'b10, 10);
        valid_held = 1'b1;
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            if (coin_valid !== 1'b1 || err !== 1'b0) valid_held = 1'b0;
        end
        checkOutput("tmo_waiting", 32'(valid_held), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("tmo_err", 32'(err), 32'd1);
        checkOutput("tmo_valid", 32'(coin_valid), 32'd0);
        checkOutput("tmo_rem", 32'(remaining), 32'd10);
        checkOutput("tmo_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 3, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("tmo_err_sticky", 32'(err), 32'd1);
        checkOutput("tmo_rem_frozen", 32'(remaining), 32'd10);
        checkOutput("tmo_valid_off", 32'(coin_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkIdleReset("tmo_reset");

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
